// File: rtl/ifu_pkg.sv
// Shared fetch/control definitions: NPC select encodings, IFU states, reset PC and opcodes.
// Imported by ifu, ifu_npc and the main decoder.
package ifu_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // NPCOp encodings (shared with ctrl)
  localparam logic [1:0] NPC_PLUS4  = 2'b00;
  localparam logic [1:0] NPC_BRANCH = 2'b01;
  localparam logic [1:0] NPC_JUMP   = 2'b10;
  localparam logic [1:0] NPC_JR     = 2'b11;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } ifuState_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Word-scaled sign-extended branch offset
  function automatic logic [31:0] branchOffset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

// File: rtl/ifu_npc.sv
// Next-PC selection for the fetch unit (purely combinational).
// Build option IFU_JR_EN: NPCOp=11 selects the word-aligned jr target instead of PC+4.
module ifu_npc
  import ifu_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_imm26,
  input  logic        i_zero,
  input  logic [1:0]  i_npcOp,
  input  logic [31:0] i_jrTarget,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc4;
  logic [31:0] w_branchPc;
  logic [31:0] w_jumpPc;

  assign w_pc4      = i_pc + 32'd4;
  assign w_branchPc = w_pc4 + branchOffset(i_imm26[15:0]);
  assign w_jumpPc   = {i_pc[31:28], i_imm26, 2'b00};

`ifdef IFU_JR_EN
  logic w_unusedJr;
  assign w_unusedJr = ^i_jrTarget[1:0];
`else
  logic w_unusedJr;
  assign w_unusedJr = ^i_jrTarget;
`endif

  always_comb begin
    o_npc = w_pc4;
    unique case (i_npcOp)
      NPC_PLUS4:  o_npc = w_pc4;
      NPC_BRANCH: o_npc = i_zero ? w_branchPc : w_pc4;
      NPC_JUMP:   o_npc = w_jumpPc;
      NPC_JR: begin
`ifdef IFU_JR_EN
        o_npc = {i_jrTarget[31:2], 2'b00};
`else
        o_npc = w_pc4;
`endif
      end
      default:    o_npc = w_pc4;
    endcase
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC/IR registers and a two-state fetch/execute FSM over an IM req/ack handshake.
// Build option IFU_JR_EN (in ifu_npc) enables jr via NPCOp=11.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
  parameter int          IM_ADDR_W = 10
)
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PCWr,
  input  logic                 IRWr,
  input  logic [1:0]           NPCOp,
  input  logic                 Zero,
  input  logic [31:0]          jr_target,
  output logic                 im_req,
  output logic [IM_ADDR_W-1:0] im_addr,
  input  logic                 im_ack,
  input  logic [31:0]          im_rdata,
  output logic [31:0]          IR,
  output logic [31:0]          PC,
  output logic [31:0]          PC4,
  output logic                 instr_valid
);

  ifuState_e   r_state;
  ifuState_e   w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [31:0] w_npc;
  logic        w_loadIr;
  logic        w_commitPc;

  ifu_npc u_npc (
    .i_pc       (r_pc),
    .i_imm26    (r_ir[25:0]),
    .i_zero     (Zero),
    .i_npcOp    (NPCOp),
    .i_jrTarget (jr_target),
    .o_npc      (w_npc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_pc    <= PC_RESET;
      r_ir    <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_loadIr)   r_ir <= im_rdata;
      if (w_commitPc) r_pc <= w_npc;
    end
  end

  // Request is masked during reset so an ack arriving then is never consumed.
  always_comb begin
    w_nextState = r_state;
    w_loadIr    = 1'b0;
    w_commitPc  = 1'b0;
    im_req      = 1'b0;
    instr_valid = 1'b0;
    unique case (r_state)
      S_FETCH: begin
        im_req = ~rst;
        if (im_ack && IRWr) begin
          w_loadIr    = 1'b1;
          w_nextState = S_EXEC;
        end
      end
      S_EXEC: begin
        instr_valid = ~rst;
        if (PCWr) begin
          w_commitPc  = 1'b1;
          w_nextState = S_FETCH;
        end
      end
      default: w_nextState = S_FETCH;
    endcase
  end

  assign im_addr = r_pc[IM_ADDR_W+1:2];
  assign IR      = r_ir;
  assign PC      = r_pc;
  assign PC4     = r_pc + 32'd4;

endmodule
